// File: rtl/row_pp_pkg.sv
// row_pp_pkg: shared widths and binary16 constants for the row post-processing
// slice (row_post_process, fp16_scale_unit).
package row_pp_pkg;
  localparam int IN_W    = 32;   // int32 accumulator per column
  localparam int SCALE_W = 16;   // binary16 scale per column
  localparam int OUT_W   = 16;   // binary16 result per column

  localparam logic [15:0] POS_INF    = 16'h7C00;
  localparam logic [15:0] NEG_INF    = 16'hFC00;
  localparam logic [15:0] QNAN       = 16'h7E00;
  localparam logic [15:0] MAX_FINITE = 16'h7BFF;
endpackage

// File: rtl/fp16_scale_unit.sv
// fp16_scale_unit: one column of the post-processor.
//   stage 1: int32 -> binary16 (RNE) registered together with the scale
//   stage 2: binary16 * binary16 (RNE) registered as the result
// Ports:
//   clk, rst_n       clock; synchronous active-high reset
//   row_valid        loads stage 1 (raw/scale qualified this cycle)
//   stage_valid      loads stage 2 (stage 1 holds a valid row)
//   raw   [31:0]     signed int32 input
//   scale [15:0]     binary16 scale
//   result[15:0]     binary16 product
module fp16_scale_unit
  import row_pp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               row_valid,
  input  logic               stage_valid,
  input  logic [IN_W-1:0]    raw,
  input  logic [SCALE_W-1:0] scale,
  output logic [OUT_W-1:0]   result
);

  function automatic logic [15:0] to_fp16(input logic [31:0] x);
    logic        sgn;
    logic [31:0] mag;
    logic [31:0] below;
    int          p;
    int          sh;
    logic [10:0] m;
    logic        g;
    logic        st;
    logic [11:0] mr;
    logic [15:0] cand;
    sgn   = x[31];
    mag   = sgn ? (~x + 32'd1) : x;   // -2^31 becomes 2^31 as unsigned
    p     = 0;
    below = '0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) p = i;
    if (mag == '0) return 16'h0000;
    if (p <= 10) begin
      m  = 11'(mag << (10 - p));
      g  = 1'b0;
      st = 1'b0;
    end else begin
      sh    = p - 10;
      m     = 11'(mag >> sh);
      g     = mag[sh-1];
      below = (32'd1 << (sh - 1)) - 32'd1;
      st    = |(mag & below);
    end
    mr = {1'b0, m} + {11'd0, g & (st | m[0])};
    // A carry out of the mantissa means 2.0: bump the exponent, fraction is already zero.
    cand = {6'(p + 15 + int'(mr[11])), mr[9:0]};
    if (cand > MAX_FINITE) return sgn ? NEG_INF : POS_INF;
    return {sgn, cand[14:0]};
  endfunction

  // The converted operand is never NaN or subnormal, so only b needs full classification.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic        a_inf;
    logic        a_zero;
    logic        b_inf;
    logic        b_zero;
    logic        b_nan;
    logic        g;
    logic        st;
    logic [21:0] prod;
    logic [9:0]  m;
    logic [11:0] mr;
    int          e;
    s      = a[15] ^ b[15];
    a_inf  = (a[14:10] == 5'h1F);
    a_zero = (a[14:10] == 5'h00);
    b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    b_zero = (b[14:10] == 5'h00);   // subnormal scales count as zero
    prod   = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e      = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (prod[21]) begin
      m  = prod[20:11];
      g  = prod[10];
      st = |prod[9:0];
      e  = e + 1;
    end else begin
      m  = prod[19:10];
      g  = prod[9];
      st = |prod[8:0];
    end
    mr = {2'b01, m} + {11'd0, g & (st | m[0])};
    if (mr[11]) e = e + 1;
    if (b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return QNAN;
    if (a_inf || b_inf)   return s ? NEG_INF : POS_INF;
    if (a_zero || b_zero) return {s, 15'd0};
    if (e >= 31)          return s ? NEG_INF : POS_INF;
    if (e <= 0)           return {s, 15'd0};   // subnormal results flush
    return {s, 5'(e), mr[9:0]};
  endfunction

  logic [15:0] op_q;
  logic [15:0] scale_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      op_q    <= '0;
      scale_q <= '0;
      result  <= '0;
    end else begin
      if (row_valid) begin
        op_q    <= to_fp16(raw);
        scale_q <= scale;
      end
      if (stage_valid) result <= fp16_mul(op_q, scale_q);
    end
  end

endmodule

// File: rtl/row_post_process.sv
// row_post_process: scales each int32 systolic-array column by a per-column
// binary16 factor and emits binary16, two-cycle latency for column 0.
// Macro ROW_PP_DIAG_SKEW_EN: when defined, column c is delayed c extra cycles
// through a shift register (diagonal wavefront); when undefined all columns
// are aligned with column 0 and no skew storage exists.
// Ports:
//   clk, rst_n              clock; synchronous active-high reset
//   sys_array_out_32b       int32 per column at [c*32 +: 32]
//   array_out_valid         qualifies data and scales this cycle
//   col_scale_factors       binary16 scale per column at [c*16 +: 16]
//   fp16_out_diagonal       binary16 result per column at [c*16 +: 16]
//   fp16_valid_diagonal     qualifies column 0 of fp16_out_diagonal
module row_post_process
  import row_pp_pkg::*;
#(
  parameter int COL_NUM         = 32,
  parameter int BIT_WIDTH_IN    = IN_W,
  parameter int BIT_WIDTH_SCALE = SCALE_W,
  parameter int BIT_WIDTH_OUT   = OUT_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [COL_NUM*BIT_WIDTH_IN-1:0]    sys_array_out_32b,
  input  logic                               array_out_valid,
  input  logic [COL_NUM*BIT_WIDTH_SCALE-1:0] col_scale_factors,
  output logic [COL_NUM*BIT_WIDTH_OUT-1:0]   fp16_out_diagonal,
  output logic                               fp16_valid_diagonal
);

  localparam int STAGES = 2;

  // vld_pipe[s] is high when pipeline stage s holds a valid row.
  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst_n) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:1], array_out_valid};
  end

  assign fp16_valid_diagonal = vld_pipe[STAGES];

  logic [COL_NUM-1:0][BIT_WIDTH_OUT-1:0] prod;
  logic [COL_NUM-1:0][BIT_WIDTH_OUT-1:0] lane_out;

  for (genvar c = 0; c < COL_NUM; c++) begin : g_col
    fp16_scale_unit u_unit (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_valid   (array_out_valid),
      .stage_valid (vld_pipe[1]),
      .raw         (sys_array_out_32b[c*BIT_WIDTH_IN +: BIT_WIDTH_IN]),
      .scale       (col_scale_factors[c*BIT_WIDTH_SCALE +: BIT_WIDTH_SCALE]),
      .result      (prod[c])
    );

`ifdef ROW_PP_DIAG_SKEW_EN
    if (c == 0) begin : g_noskew
      assign lane_out[c] = prod[c];
    end else begin : g_skew
      // Free-running shift: every column advances every cycle so the
      // wavefront stays locked to column 0 regardless of valid gaps.
      logic [BIT_WIDTH_OUT-1:0] sr [c];
      always_ff @(posedge clk) begin
        if (rst_n) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else begin
          sr[0] <= prod[c];
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign lane_out[c] = sr[c-1];
    end
`else
    assign lane_out[c] = prod[c];
`endif
  end

  assign fp16_out_diagonal = lane_out;

endmodule

// File: tb/tb_row_post_process.sv
// tb_row_post_process: directed self-checking bench for row_post_process.
// Inputs are driven and outputs sampled on the falling edge; a row driven at
// falling edge n is expected on the outputs at falling edge n+2.
module tb_row_post_process;
  localparam int COL = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [COL*32-1:0] din;
  logic              vin;
  logic [COL*16-1:0] scl;
  logic [COL*16-1:0] dout;
  logic              vout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  row_post_process #(.COL_NUM(COL)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sys_array_out_32b   (din),
    .array_out_valid     (vin),
    .col_scale_factors   (scl),
    .fp16_out_diagonal   (dout),
    .fp16_valid_diagonal (vout)
  );

  // Stimulus helper: exact binary16 for small non-negative integers.
  function automatic logic [15:0] small_fp16(input int n);
    int p;
    p = 0;
    for (int i = 0; i < 12; i++)
      if (n[i]) p = i;
    if (n == 0) return 16'h0000;
    return {1'b0, 5'(p + 15), 10'(n << (10 - p))};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_data(input logic [31:0] d);
    for (int c = 0; c < COL; c++) din[c*32 +: 32] = d;
  endtask

  task automatic set_scale(input logic [15:0] s);
    for (int c = 0; c < COL; c++) scl[c*16 +: 16] = s;
  endtask

  // One isolated row on all columns with a common scale; check column 0.
  task automatic corner(input string tag, input logic [31:0] d, input logic [15:0] s,
                        input logic [15:0] exp);
    @(negedge clk);
    set_data(d);
    set_scale(s);
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    @(negedge clk);
    chk({tag, "_c0"}, dout[15:0], exp);
    chk({tag, "_vld"}, {15'd0, vout}, 16'd1);
`ifndef ROW_PP_DIAG_SKEW_EN
    chk({tag, "_c31"}, dout[31*16 +: 16], exp);
`endif
  endtask

  logic [15:0] tab1  [10] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                              16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900};
  logic [15:0] tab10 [10] = '{16'h4900, 16'h4D00, 16'h4F80, 16'h5100, 16'h5240,
                              16'h5380, 16'h5460, 16'h5500, 16'h55A0, 16'h5640};
  logic        obs_v   [25];
  logic [15:0] obs_c0  [25];
  logic [15:0] obs_c1  [25];
  logic [15:0] obs_c10 [25];

`ifdef ROW_PP_DIAG_SKEW_EN
  localparam int SK = 1;
`else
  localparam int SK = 0;
`endif

  initial begin
    rst_n = 1'b1;
    vin   = 1'b0;
    din   = '0;
    scl   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_bus", {15'd0, |dout}, 16'd0);
    chk("rst_vld", {15'd0, vout}, 16'd0);
    rst_n = 1'b0;

    // Mid-burst reset: rows carry t+1 with scale 1.0, reset driven with row 4
    set_scale(16'h3C00);
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (t == 5 || t == 6) begin
        chk($sformatf("midrst_bus_t%0d", t), {15'd0, |dout}, 16'd0);
        chk($sformatf("midrst_vld_t%0d", t), {15'd0, vout}, 16'd0);
      end
      if (t == 7) begin
        chk("midrst_row5", dout[15:0], 16'h4600);
        chk("midrst_row5_vld", {15'd0, vout}, 16'd1);
      end
      if (t == 8) chk("midrst_row6", dout[15:0], 16'h4700);
      rst_n = (t == 4);
      set_data(32'(t + 1));
      vin = (t < 10);
    end

    // Burst: scale of column c is c, inputs 1..10 on every column
    for (int c = 0; c < COL; c++) scl[c*16 +: 16] = small_fp16(c);
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      obs_v[t]   = vout;
      obs_c0[t]  = dout[15:0];
      obs_c1[t]  = dout[16 +: 16];
      obs_c10[t] = dout[160 +: 16];
      set_data(32'(t + 1));
      vin = (t < 10);
    end
    for (int t = 0; t < 25; t++)
      chk($sformatf("burst_vld_t%0d", t), {15'd0, obs_v[t]}, {15'd0, (t >= 2 && t <= 11)});
    for (int r = 0; r < 10; r++) begin
      chk($sformatf("burst_c0_r%0d", r),  obs_c0[r+2],         16'h0000);
      chk($sformatf("burst_c1_r%0d", r),  obs_c1[r+2+SK],      tab1[r]);
      chk($sformatf("burst_c10_r%0d", r), obs_c10[r+2+SK*10],  tab10[r]);
    end

    // Special values and rounding
    corner("nan_scale",  32'hFFFF_FFFF, 16'h7E00, 16'h7E00);
    corner("ovf_conv",   32'd70000,     16'h3C00, 16'h7C00);
    corner("ovf_mul",    32'd100,       16'h63D0, 16'h7C00);
    corner("neg_half",   32'hFFFF_FFFC, 16'h3800, 16'hC000);
    corner("neg_zero",   32'hFFFF_FFFB, 16'h0000, 16'h8000);
    corner("inf_x_zero", 32'd70000,     16'h0000, 16'h7E00);
    corner("int_min",    32'h8000_0000, 16'h3C00, 16'hFC00);
    corner("subn_scale", 32'd7,         16'h0200, 16'h0000);
    corner("min_norm",   32'd1,         16'h0400, 16'h0400);
    corner("tie_even",   32'd2049,      16'h3C00, 16'h6800);
    corner("round_up",   32'd2051,      16'h3C00, 16'h6802);

`ifdef ROW_PP_DIAG_SKEW_EN
    // Diagonal wavefront: 5 * 2.0 on every column
    @(negedge clk);
    set_data(32'd5);
    set_scale(16'h4000);
    vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    @(negedge clk);
    chk("skew_c0", dout[15:0], 16'h4900);
    chk("skew_vld", {15'd0, vout}, 16'd1);
    for (int j = 1; j <= 31; j++) begin
      @(negedge clk);
      if (j == 30) begin
        checks++;
        assert (dout[31*16 +: 16] !== 16'h4900) else begin
          errors++;
          $error("FAIL skew_c31_early: observed %h expected not 4900", dout[31*16 +: 16]);
        end
      end
      if (j == 31) chk("skew_c31", dout[31*16 +: 16], 16'h4900);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
